window_line_buffer: RTL and testbench

Parametrised single-line pixel store with a sliding-window read port. Pixels enter through a valid-qualified write port. The read side emits WIN_W consecutive pixels per read, then advances one pixel, all through a registered valid/ready output. Several instances are stacked to form the row buffers of a WIN_W x WIN_W convolution window front-end. Adds occupancy tracking, full/empty flags, overflow detection, read gating, synchronous flush and modulo wrap-around.

---
 rtl/img_pkg.sv | 10 +
 rtl/lb_ram.sv | 31 +++
 rtl/window_line_buffer.sv | 114 +++++++++++
 tb/tb_window_line_buffer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared pixel-format definitions for the image front-end line buffers.
package img_pkg;

  localparam int unsigned PIXEL_W      = 8;
  localparam int unsigned DEF_LINE_LEN = 512;
  localparam int unsigned DEF_WIN_W    = 3;

  typedef logic [PIXEL_W-1:0] pixel_t;

endpackage : img_pkg

// File: rtl/lb_ram.sv
// Line storage: one synchronous write port and WIN_W combinational read ports
// at consecutive addresses (modulo LINE_LEN), oldest pixel in the MSB slice.
module lb_ram #(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned LINE_LEN = 512,
  parameter  int unsigned WIN_W    = 3,
  localparam int unsigned PTR_W    = $clog2(LINE_LEN)
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [PTR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [PTR_W-1:0]        rd_addr,
  output logic [WIN_W*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [LINE_LEN];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Reads see the pre-edge contents, so a same-cycle write is never visible.
  for (genvar i = 0; i < WIN_W; i++) begin : g_rd
    logic [PTR_W-1:0] addr;
    assign addr = rd_addr + PTR_W'(i);
    assign rd_data[(WIN_W-1-i)*DATA_W +: DATA_W] = mem[addr];
  end

endmodule : lb_ram

// File: rtl/window_line_buffer.sv
// Single-line pixel store with a sliding WIN_W-pixel window read port,
// occupancy tracking, overflow detection and synchronous flush.
module window_line_buffer
  import img_pkg::*;
#(
  parameter  int unsigned DATA_W   = PIXEL_W,
  parameter  int unsigned LINE_LEN = DEF_LINE_LEN,
  parameter  int unsigned WIN_W    = DEF_WIN_W,
  localparam int unsigned PTR_W    = $clog2(LINE_LEN),
  localparam int unsigned CNT_W    = $clog2(LINE_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       pixel_in,
  input  logic                    pixel_in_valid,
  output logic                    pixel_in_ready,
  input  logic                    win_ready,
  output logic                    win_valid,
  output logic [WIN_W*DATA_W-1:0] win_out,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow
);

  logic [PTR_W-1:0]        wr_ptr, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr, rd_ptr_d;
  logic [CNT_W-1:0]        count_d;
  logic                    win_valid_d;
  logic [WIN_W*DATA_W-1:0] win_out_d;
  logic                    overflow_d;
  logic [WIN_W*DATA_W-1:0] rd_data;
  logic                    wr_en;
  logic                    avail;
  logic                    load;

  // Flags are pure decodes of the occupancy counter.
  assign full           = (count == CNT_W'(LINE_LEN));
  assign empty          = (count == '0);
  assign pixel_in_ready = !full;

  assign avail = (count >= CNT_W'(WIN_W));
  assign wr_en = pixel_in_valid && pixel_in_ready && !flush;
  assign load  = avail && (!win_valid || win_ready) && !flush;

  lb_ram #(
    .DATA_W   (DATA_W),
    .LINE_LEN (LINE_LEN),
    .WIN_W    (WIN_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (pixel_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Next-state: flush wins over write and load in the same cycle.
  always_comb begin
    wr_ptr_d    = wr_ptr;
    rd_ptr_d    = rd_ptr;
    count_d     = count;
    win_valid_d = win_valid;
    win_out_d   = win_out;
    overflow_d  = overflow;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      win_valid_d = 1'b0;
      win_out_d   = '0;
      overflow_d  = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr + PTR_W'(1);
      if (pixel_in_valid && full) overflow_d = 1'b1;

      if (load) begin
        win_out_d   = rd_data;
        win_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr + PTR_W'(1);
      end else if (win_valid && win_ready) begin
        win_valid_d = 1'b0;
      end

      unique case ({wr_en, load})
        2'b10:   count_d = count + CNT_W'(1);
        2'b01:   count_d = count - CNT_W'(1);
        default: count_d = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      win_valid <= 1'b0;
      win_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      count     <= count_d;
      win_valid <= win_valid_d;
      win_out   <= win_out_d;
      overflow  <= overflow_d;
    end
  end

endmodule : window_line_buffer

// File: tb/tb_window_line_buffer.sv
// Directed bench for window_line_buffer: vector table plus multi-cycle sequences.
module tb_window_line_buffer;

  localparam int unsigned DW = 8;
  localparam int unsigned LL = 512;
  localparam int unsigned WW = 3;
  localparam int unsigned CW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] pixel_in;
  logic          pixel_in_valid;
  logic          pixel_in_ready;
  logic          win_ready;
  logic          win_valid;
  logic [WW*DW-1:0] win_out;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  window_line_buffer #(.DATA_W(DW), .LINE_LEN(LL), .WIN_W(WW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .pixel_in       (pixel_in),
    .pixel_in_valid (pixel_in_valid),
    .pixel_in_ready (pixel_in_ready),
    .win_ready      (win_ready),
    .win_valid      (win_valid),
    .win_out        (win_out),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow)
  );

  typedef struct {
    logic          flush;
    logic          valid;
    logic [7:0]    px;
    logic          ready;
    logic          exp_wv;
    logic [23:0]   exp_win;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic f, input logic v, input logic [7:0] p, input logic r);
    flush          = f;
    pixel_in_valid = v;
    pixel_in       = p;
    win_ready      = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] spx(input int k);
    return 8'(k + 18);
  endfunction

  initial begin
    int n;
    int j;
    logic [23:0] exp_w;

    vecs[0]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 24'h0,      10'd1};
    vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 24'h0,      10'd2};
    vecs[2]  = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 24'h0,      10'd3};
    vecs[3]  = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 24'h010203, 10'd3};
    vecs[4]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 24'h020304, 10'd3};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 24'h030405, 10'd2};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 24'h0,      10'd2};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0,      10'd0};
    vecs[8]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 24'h0,      10'd1};
    vecs[9]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 24'h0,      10'd2};
    vecs[10] = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 24'h0,      10'd3};
    for (int i = 11; i < 16; i++)
      vecs[i] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 24'h010203, 10'd2};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 24'h0,      10'd2};

    rst_n = 1'b0; flush = 1'b0; pixel_in = '0; pixel_in_valid = 1'b0; win_ready = 1'b0;
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wv", 64'(win_valid), 64'd0);
    chk("rst_win", 64'(win_out), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ready", 64'(pixel_in_ready), 64'd1);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream/stall vector table
    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].flush, vecs[i].valid, vecs[i].px, vecs[i].ready);
      chk($sformatf("row%0d_wv", i), 64'(win_valid), 64'(vecs[i].exp_wv));
      chk($sformatf("row%0d_cnt", i), 64'(count), 64'(vecs[i].exp_cnt));
      if (vecs[i].exp_wv)
        chk($sformatf("row%0d_win", i), 64'(win_out), 64'(vecs[i].exp_win));
    end
    chk("flush_row_empty_now", 64'(empty), 64'd0);

    // Fill to full with the output stalled; one window is pulled out early
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (!full && n < 600) begin
      cyc(1'b0, 1'b1, 8'(n), 1'b0);
      n++;
    end
    chk("fill_writes", 64'(n), 64'd513);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ready", 64'(pixel_in_ready), 64'd0);
    chk("fill_count", 64'(count), 64'd512);
    chk("fill_win", 64'(win_out), 64'h000102);
    chk("fill_ovf_pre", 64'(overflow), 64'd0);
    cyc(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd512);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    chk("ovf_win_hold", 64'(win_out), 64'h000102);
    cyc(1'b1, 1'b1, 8'h55, 1'b1);
    chk("flushf_count", 64'(count), 64'd0);
    chk("flushf_empty", 64'(empty), 64'd1);
    chk("flushf_wv", 64'(win_valid), 64'd0);
    chk("flushf_ovf", 64'(overflow), 64'd0);
    chk("flushf_ready", 64'(pixel_in_ready), 64'd1);

    // Flush with count=7 and a valid window
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'(i + 1), 1'b0);
    chk("pre7_count", 64'(count), 64'd7);
    chk("pre7_wv", 64'(win_valid), 64'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("flush7_count", 64'(count), 64'd0);
    chk("flush7_empty", 64'(empty), 64'd1);
    chk("flush7_wv", 64'(win_valid), 64'd0);
    chk("flush7_ovf", 64'(overflow), 64'd0);

    // Steady-state streaming across the LINE_LEN wrap
    for (int c = 1; c <= 600; c++) begin
      cyc(1'b0, 1'b1, spx(c - 1), 1'b1);
      chk($sformatf("strm%0d_cnt", c), 64'(count), 64'((c < 3) ? c : 3));
      if (c >= 4) begin
        j = c - 4;
        exp_w = {spx(j), spx(j + 1), spx(j + 2)};
        chk($sformatf("strm%0d_wv", c), 64'(win_valid), 64'd1);
        chk($sformatf("strm%0d_win", c), 64'(win_out), 64'(exp_w));
        if (j == 510) chk("wrap_win", 64'(win_out), 64'h101112);
      end
    end

    // Asynchronous reset mid-window, away from any clock edge
    pixel_in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wv", 64'(win_valid), 64'd0);
    chk("arst_win", 64'(win_out), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_ready", 64'(pixel_in_ready), 64'd1);
    chk("arst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_window_line_buffer
